// File: rtl/tetris_pkg.sv
// Shared piece/bag types and queue FSM encoding for the piece queue slice.
package tetris_pkg;
  localparam int PIECE_W = 3;
  localparam int BAG_N   = 7;
  localparam int BAG_W   = PIECE_W * BAG_N;

  typedef logic [PIECE_W-1:0] piece_t;
  typedef logic [BAG_W-1:0]   bag_t;

  localparam piece_t NO_PIECE  = 3'b111;
  localparam bag_t   EMPTY_BAG = {BAG_N{NO_PIECE}};

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2
  } queue_state_e;
endpackage

// File: rtl/bag_shifter.sv
// Seven-entry piece shift register: slot 0 is the head, empties refill with NO_PIECE.
// Priority: load > clr > shift > set0 (set0 rewrites the head slot only).
module bag_shifter
  import tetris_pkg::*;
(
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 load,
  input  logic [BAG_W-1:0]     load_data,
  input  logic                 clr,
  input  logic                 shift,
  input  logic                 set0,
  input  logic [PIECE_W-1:0]   set0_data,
  output logic [BAG_W-1:0]     data,
  output logic [2:0]           cnt
);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      data <= EMPTY_BAG;
      cnt  <= 3'd0;
    end else if (load) begin
      data <= load_data;
      cnt  <= 3'(BAG_N);
    end else if (clr) begin
      data <= EMPTY_BAG;
      cnt  <= 3'd0;
    end else if (shift && cnt != 3'd0) begin
      data <= {NO_PIECE, data[BAG_W-1:PIECE_W]};
      cnt  <= cnt - 3'd1;
    end else if (set0) begin
      data[PIECE_W-1:0] <= set0_data;
    end
  end

endmodule

// File: rtl/piece_queue.sv
// Double-buffered piece queue between the bag generator and game control.
// Optional hold slot is built only when PIECE_QUEUE_HOLD_EN is defined.
module piece_queue
  import tetris_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        bag_ready,
  input  logic [20:0] bag_pieces,
  output logic        newbag,
  input  logic        pop,
  input  logic        hold_req,
  output logic [2:0]  piece,
  output logic        piece_valid,
  output logic [2:0]  next_piece,
  output logic        next_valid,
  output logic [2:0]  held_piece,
  output logic        held_valid,
  output logic [7:0]  bags_used,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_FULL = FULL;

  logic [1:0]          state;
  logic                armed;
  logic [BAG_W-1:0]    active_data;
  logic [BAG_W-1:0]    staged_data;
  logic [2:0]          active_cnt;
  logic [2:0]          staged_cnt;
  logic                staged_valid;
  logic                hold_pop;
  logic                hold_swap;
  piece_t              swap_piece;
  logic                pop_eff;
  logic                shift_req;
  logic [2:0]          cnt_after;
  logic                transfer;
  logic                active_has_after;
  logic                staged_has_after;
  logic                cap;
  logic                cap_active;
  logic                cap_staged;
  logic [BAG_W-1:2*PIECE_W] unused_active_tail;

  assign piece_valid  = (active_cnt != 3'd0);
  assign piece        = active_data[PIECE_W-1:0];
  assign staged_valid = (staged_cnt != 3'd0);
  assign unused_active_tail = active_data[BAG_W-1:2*PIECE_W];
  assign state_dbg    = state;

  // Preview falls through to the staged bag once active is down to one piece.
  always_comb begin
    next_valid = 1'b0;
    next_piece = NO_PIECE;
    if (active_cnt >= 3'd2) begin
      next_valid = 1'b1;
      next_piece = active_data[2*PIECE_W-1:PIECE_W];
    end else if (staged_valid) begin
      next_valid = 1'b1;
      next_piece = staged_data[PIECE_W-1:0];
    end
  end

  assign pop_eff   = pop && piece_valid;
  assign shift_req = pop_eff || hold_pop;
  assign cnt_after = active_cnt - {2'b00, shift_req};
  assign transfer  = shift_req && (active_cnt == 3'd1) && staged_valid;

  // Capture target is decided on the post-pop view of both buffers.
  assign active_has_after = (cnt_after != 3'd0) || transfer;
  assign cap              = (state == S_WAIT) && armed && bag_ready;
  assign cap_active       = cap && !active_has_after;
  assign cap_staged       = cap && active_has_after;
  assign staged_has_after = cap_staged || (staged_valid && !transfer);

`ifdef PIECE_QUEUE_HOLD_EN
  logic   hold_lock;
  logic   hold_eff;
  piece_t held_q;
  logic   held_v;

  assign hold_eff   = hold_req && piece_valid && !hold_lock && !pop;
  assign hold_pop   = hold_eff && !held_v;
  assign hold_swap  = hold_eff && held_v;
  assign swap_piece = held_q;
  assign held_piece = held_q;
  assign held_valid = held_v;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      hold_lock <= 1'b0;
      held_q    <= NO_PIECE;
      held_v    <= 1'b0;
    end else begin
      if (hold_eff) begin
        hold_lock <= 1'b1;
        held_q    <= piece;
        held_v    <= 1'b1;
      end else if (pop_eff) begin
        hold_lock <= 1'b0;
      end
    end
  end
`else
  logic unused_hold;

  assign unused_hold = hold_req;
  assign hold_pop    = 1'b0;
  assign hold_swap   = 1'b0;
  assign swap_piece  = NO_PIECE;
  assign held_piece  = NO_PIECE;
  assign held_valid  = 1'b0;
`endif

  bag_shifter u_active (
    .clk       (clk),
    .nreset    (nreset),
    .load      (transfer || cap_active),
    .load_data (transfer ? staged_data : bag_pieces),
    .clr       (1'b0),
    .shift     (shift_req),
    .set0      (hold_swap),
    .set0_data (swap_piece),
    .data      (active_data),
    .cnt       (active_cnt)
  );

  bag_shifter u_staged (
    .clk       (clk),
    .nreset    (nreset),
    .load      (cap_staged),
    .load_data (bag_pieces),
    .clr       (transfer),
    .shift     (1'b0),
    .set0      (1'b0),
    .set0_data (NO_PIECE),
    .data      (staged_data),
    .cnt       (staged_cnt)
  );

  // armed guards against capturing a ready level left over from the last bag.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state     <= S_REQ;
      armed     <= 1'b0;
      newbag    <= 1'b0;
      bags_used <= 8'd0;
    end else begin
      newbag <= 1'b0;
      if (cap_active || transfer) bags_used <= bags_used + 8'd1;
      case (state)
        S_REQ: begin
          newbag <= 1'b1;
          armed  <= 1'b0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (cap) begin
            armed <= 1'b0;
            state <= staged_has_after ? S_FULL : S_REQ;
          end else if (!bag_ready) begin
            armed <= 1'b1;
          end
        end
        S_FULL: begin
          if (!(active_has_after && staged_has_after)) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_queue.sv
// Directed table-driven bench for piece_queue; hold checks depend on PIECE_QUEUE_HOLD_EN.
module tb_piece_queue;

  typedef struct {
    logic        nr;
    logic        rdy;
    logic [20:0] bag;
    logic        pop;
    logic        hold;
    logic        nb;
    logic        pv;
    logic [2:0]  pc;
    logic        nv;
    logic [2:0]  np;
    logic [7:0]  bu;
    logic [1:0]  st;
  } vec_t;

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  logic        clk;
  logic        nreset;
  logic        bag_ready;
  logic [20:0] bag_pieces;
  logic        newbag;
  logic        pop;
  logic        hold_req;
  logic [2:0]  piece;
  logic        piece_valid;
  logic [2:0]  next_piece;
  logic        next_valid;
  logic [2:0]  held_piece;
  logic        held_valid;
  logic [7:0]  bags_used;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vq[$];

  piece_queue dut (
    .clk         (clk),
    .nreset      (nreset),
    .bag_ready   (bag_ready),
    .bag_pieces  (bag_pieces),
    .newbag      (newbag),
    .pop         (pop),
    .hold_req    (hold_req),
    .piece       (piece),
    .piece_valid (piece_valid),
    .next_piece  (next_piece),
    .next_valid  (next_valid),
    .held_piece  (held_piece),
    .held_valid  (held_valid),
    .bags_used   (bags_used),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] pk(input logic [2:0] p0, p1, p2, p3, p4, p5, p6);
    return {p6, p5, p4, p3, p2, p1, p0};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input logic nr, input logic rdy, input logic [20:0] b,
                      input logic p, input logic h);
    @(negedge clk);
    nreset     = nr;
    bag_ready  = rdy;
    bag_pieces = b;
    pop        = p;
    hold_req   = h;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic nr, input logic rdy, input logic [20:0] b,
                     input logic p, input logic h, input logic nb, input logic pv,
                     input logic [2:0] pc, input logic nv, input logic [2:0] np,
                     input logic [7:0] bu, input logic [1:0] st);
    vec_t v;
    v.nr = nr; v.rdy = rdy; v.bag = b; v.pop = p; v.hold = h;
    v.nb = nb; v.pv = pv; v.pc = pc; v.nv = nv; v.np = np; v.bu = bu; v.st = st;
    vq.push_back(v);
  endtask

  logic [20:0] bag_a;
  logic [20:0] bag_b;
  logic [20:0] bag_c;

  initial begin
    nreset = 1'b0; bag_ready = 1'b1; bag_pieces = '0; pop = 1'b0; hold_req = 1'b0;
    bag_a = pk(0, 1, 2, 3, 4, 5, 6);   // 21'h1AC688
    bag_b = pk(6, 5, 4, 3, 2, 1, 0);
    bag_c = pk(4, 2, 5, 0, 1, 3, 3);

    //   nr rdy bag    pop hld | nb pv pc nv np bu st
    add(0, 1, 21'h0, 0, 0,     0, 0, 7, 0, 7, 0, ST_REQ);
    add(1, 1, 21'h0, 0, 0,     1, 0, 7, 0, 7, 0, ST_WAIT);
    add(1, 1, bag_a, 0, 0,     0, 0, 7, 0, 7, 0, ST_WAIT);   // stale ready ignored
    add(1, 1, bag_a, 0, 0,     0, 0, 7, 0, 7, 0, ST_WAIT);
    add(1, 0, bag_a, 0, 0,     0, 0, 7, 0, 7, 0, ST_WAIT);
    add(1, 1, bag_a, 0, 0,     0, 1, 0, 1, 1, 1, ST_REQ);    // capture into active
    add(1, 1, bag_a, 0, 0,     1, 1, 0, 1, 1, 1, ST_WAIT);
    add(1, 1, bag_b, 0, 0,     0, 1, 0, 1, 1, 1, ST_WAIT);
    add(1, 0, bag_b, 0, 0,     0, 1, 0, 1, 1, 1, ST_WAIT);
    add(1, 1, bag_b, 0, 0,     0, 1, 0, 1, 1, 1, ST_FULL);   // capture into staged
    add(1, 1, bag_b, 1, 0,     0, 1, 1, 1, 2, 1, ST_FULL);
    add(1, 1, bag_b, 1, 0,     0, 1, 2, 1, 3, 1, ST_FULL);
    add(1, 1, bag_b, 1, 0,     0, 1, 3, 1, 4, 1, ST_FULL);
    add(1, 1, bag_b, 1, 0,     0, 1, 4, 1, 5, 1, ST_FULL);
    add(1, 1, bag_b, 1, 0,     0, 1, 5, 1, 6, 1, ST_FULL);
    add(1, 1, bag_b, 1, 0,     0, 1, 6, 1, 6, 1, ST_FULL);   // preview from staged
    add(1, 1, bag_b, 1, 0,     0, 1, 6, 1, 5, 2, ST_REQ);    // gapless transfer
    add(1, 1, bag_b, 0, 0,     1, 1, 6, 1, 5, 2, ST_WAIT);
    add(1, 0, bag_b, 1, 0,     0, 1, 5, 1, 4, 2, ST_WAIT);
    add(1, 0, bag_b, 1, 0,     0, 1, 4, 1, 3, 2, ST_WAIT);
    add(1, 0, bag_b, 1, 0,     0, 1, 3, 1, 2, 2, ST_WAIT);
    add(1, 0, bag_b, 1, 0,     0, 1, 2, 1, 1, 2, ST_WAIT);
    add(1, 0, bag_b, 1, 0,     0, 1, 1, 1, 0, 2, ST_WAIT);
    add(1, 0, bag_b, 1, 0,     0, 1, 0, 0, 7, 2, ST_WAIT);   // no preview left
    add(1, 0, bag_b, 1, 0,     0, 0, 7, 0, 7, 2, ST_WAIT);   // queue runs dry
    add(1, 0, bag_b, 1, 0,     0, 0, 7, 0, 7, 2, ST_WAIT);   // pop while empty ignored
    for (int i = 0; i < 12; i++)
      add(1, 0, bag_c, 0, 0,   0, 0, 7, 0, 7, 2, ST_WAIT);
    add(1, 1, bag_c, 1, 0,     0, 1, 4, 1, 2, 3, ST_REQ);    // capture straight into active
    add(1, 1, bag_c, 0, 0,     1, 1, 4, 1, 2, 3, ST_WAIT);
    add(1, 1, bag_a, 0, 0,     0, 1, 4, 1, 2, 3, ST_WAIT);
    add(1, 0, bag_a, 0, 0,     0, 1, 4, 1, 2, 3, ST_WAIT);
    add(1, 1, bag_a, 1, 0,     0, 1, 2, 1, 5, 3, ST_FULL);   // pop + capture same cycle
    add(1, 1, bag_a, 1, 0,     0, 1, 5, 1, 0, 3, ST_FULL);
    add(0, 1, bag_a, 0, 0,     0, 0, 7, 0, 7, 0, ST_REQ);    // reset from FULL
    add(1, 0, bag_a, 0, 0,     1, 0, 7, 0, 7, 0, ST_WAIT);
    add(1, 0, bag_a, 0, 0,     0, 0, 7, 0, 7, 0, ST_WAIT);
    add(0, 1, bag_a, 0, 0,     0, 0, 7, 0, 7, 0, ST_REQ);    // reset beats armed capture
    add(1, 1, bag_a, 0, 0,     1, 0, 7, 0, 7, 0, ST_WAIT);
    add(1, 1, bag_a, 0, 0,     0, 0, 7, 0, 7, 0, ST_WAIT);
    add(1, 1, bag_a, 0, 0,     0, 0, 7, 0, 7, 0, ST_WAIT);

    foreach (vq[i]) begin
      step(vq[i].nr, vq[i].rdy, vq[i].bag, vq[i].pop, vq[i].hold);
      chk("newbag",      i, 8'(newbag),      8'(vq[i].nb));
      chk("piece_valid", i, 8'(piece_valid), 8'(vq[i].pv));
      chk("piece",       i, 8'(piece),       8'(vq[i].pc));
      chk("next_valid",  i, 8'(next_valid),  8'(vq[i].nv));
      chk("next_piece",  i, 8'(next_piece),  8'(vq[i].np));
      chk("bags_used",   i, bags_used,       vq[i].bu);
      chk("state",       i, 8'(state_dbg),   8'(vq[i].st));
      chk("held_valid",  i, 8'(held_valid),  8'd0);
      chk("held_piece",  i, 8'(held_piece),  8'd7);
    end

    // hand-written hold sequence, starting from WAIT with armed clear
    step(1, 0, bag_a, 0, 0);
    step(1, 1, bag_a, 0, 0);
    chk("hs_piece", 100, 8'(piece), 8'd0);
    chk("hs_bags",  100, bags_used, 8'd1);
    step(1, 1, bag_a, 1, 0);
    step(1, 1, bag_a, 1, 0);
    chk("hs_piece", 101, 8'(piece), 8'd2);
    chk("hs_next",  101, 8'(next_piece), 8'd3);
`ifdef PIECE_QUEUE_HOLD_EN
    step(1, 1, bag_a, 0, 1);
    chk("hold_piece",  102, 8'(piece), 8'd3);
    chk("hold_next",   102, 8'(next_piece), 8'd4);
    chk("hold_held",   102, 8'(held_piece), 8'd2);
    chk("hold_hvalid", 102, 8'(held_valid), 8'd1);
    step(1, 1, bag_a, 0, 1);
    chk("lock_piece",  103, 8'(piece), 8'd3);
    chk("lock_held",   103, 8'(held_piece), 8'd2);
    step(1, 1, bag_a, 1, 0);
    chk("unlock_piece", 104, 8'(piece), 8'd4);
    chk("unlock_next",  104, 8'(next_piece), 8'd5);
    step(1, 1, bag_a, 0, 1);
    chk("swap_piece",  105, 8'(piece), 8'd2);
    chk("swap_held",   105, 8'(held_piece), 8'd4);
    chk("swap_next",   105, 8'(next_piece), 8'd5);
    chk("swap_hvalid", 105, 8'(held_valid), 8'd1);
    step(1, 1, bag_a, 1, 1);
    chk("pophold_piece", 106, 8'(piece), 8'd5);
    chk("pophold_next",  106, 8'(next_piece), 8'd6);
    chk("pophold_held",  106, 8'(held_piece), 8'd4);
`else
    step(1, 1, bag_a, 0, 1);
    chk("nohold_piece",  102, 8'(piece), 8'd2);
    chk("nohold_next",   102, 8'(next_piece), 8'd3);
    chk("nohold_hvalid", 102, 8'(held_valid), 8'd0);
    chk("nohold_held",   102, 8'(held_piece), 8'd7);
    step(1, 1, bag_a, 1, 1);
    chk("nohold_pop",    103, 8'(piece), 8'd3);
    chk("nohold_hvalid", 103, 8'(held_valid), 8'd0);
`endif
    step(1, 1, bag_a, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
